// File: rtl/pwm_period_gen_if.sv
// Duty-code handshake between the upstream quantiser (master) and the PWM period generator (slave).
interface pwm_period_gen_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/pwm_period_gen.sv
// Turns each quantised duty code into one fixed-length PWM period.
// New codes and period tops take effect only at period boundaries.
module pwm_period_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] top_in,
    pwm_period_gen_if.slave  duty,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] top_act;
    logic [WIDTH-1:0] shadow;
    logic             shadow_full;
    logic             underrun_q;
    logic             load;
    logic             bypass;
    logic             transfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A boundary load happens on leaving IDLE or at the last count of a running period.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == top_act) begin
                    if (enable) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign transfer = duty.duty_valid && duty.duty_ready;
    assign bypass   = load && !shadow_full && duty.duty_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            duty_act    <= '0;
            top_act     <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= load && !shadow_full && !duty.duty_valid;

            if (state == RUN && cnt != top_act) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            // With no fresh code at a boundary the previous duty simply repeats.
            if (load) begin
                top_act <= top_in;
                if (shadow_full) begin
                    duty_act <= shadow;
                end else if (duty.duty_valid) begin
                    duty_act <= duty.duty_in;
                end
            end

            if (load && shadow_full) begin
                shadow_full <= 1'b0;
            end else if (transfer && !bypass) begin
                shadow      <= duty.duty_in;
                shadow_full <= 1'b1;
            end
        end
    end

    assign duty.duty_ready = !shadow_full && !rst;
    assign period_start    = (state == RUN) && (cnt == '0);
    assign pwm_out         = (state == RUN) && (cnt < duty_act);
    assign underrun        = underrun_q;

endmodule
